// File: rtl/pkt_encapsulator_if.sv
// Bundle of the encapsulator's control, source-memory read and FIFO write signals.
// The master side is the encapsulator. The slave side is the router controller, memory and FIFO.
interface pkt_encapsulator_if #(
  parameter int DW = 64,
  parameter int AW = 10
);
  logic          start_encap_pkt;
  logic [AW-1:0] router_src_addr;
  logic [AW-1:0] router_dst_addr_send;
  logic [8:0]    header_pkt_send;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          encap_done;
  logic          encap_busy;

  modport master (
    input  start_encap_pkt, router_src_addr, router_dst_addr_send, header_pkt_send,
    input  mem_rd_data, fifo_full,
    output mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data, encap_done, encap_busy
  );

  modport slave (
    output start_encap_pkt, router_src_addr, router_dst_addr_send, header_pkt_send,
    output mem_rd_data, fifo_full,
    input  mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data, encap_done, encap_busy
  );
endinterface

// File: rtl/pkt_encapsulator.sv
// Reads NUMBER_PACKET payload words from source memory and writes header/payload pairs
// into the router input-port-0 FIFO, stalling on fifo_full and pulsing encap_done at the end.
module pkt_encapsulator #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int NUMBER_PACKET     = 19,
  parameter int PKT_IDX_W         = $clog2(NUMBER_PACKET)
) (
  input  logic             clk,
  input  logic             rst,
  pkt_encapsulator_if.master bus
);

  localparam int HDR_W = 9 + PKT_IDX_W + 2 * ADDR_WIDTH;
  localparam int PAD_W = AURORA_DATA_WIDTH - HDR_W;
  localparam logic [PKT_IDX_W-1:0] LAST_IDX = PKT_IDX_W'(NUMBER_PACKET - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_MEM   = 3'd1,
    WAIT_MEM = 3'd2,
    WR_HDR   = 3'd3,
    WR_DATA  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  logic [PKT_IDX_W-1:0]         pkt_idx_q, pkt_idx_d;
  logic [ADDR_WIDTH-1:0]        src_base_q, src_base_d;
  logic [ADDR_WIDTH-1:0]        dst_base_q, dst_base_d;
  logic [8:0]                   hdr_ctl_q, hdr_ctl_d;
  logic [AURORA_DATA_WIDTH-1:0] payload_q, payload_d;

  logic [ADDR_WIDTH-1:0]        src_sum_s;
  logic [ADDR_WIDTH-1:0]        dst_sum_s;
  logic [HDR_W-1:0]             hdr_fields_s;
  logic [AURORA_DATA_WIDTH-1:0] hdr_word_s;
  logic                         last_pkt_s;

  logic                         mem_rd_en_s;
  logic [ADDR_WIDTH-1:0]        mem_rd_addr_s;
  logic                         fifo_wr_en_s;
  logic [AURORA_DATA_WIDTH-1:0] fifo_wr_data_s;
  logic                         encap_done_s;
  logic                         encap_busy_s;

  // Address sums wrap naturally at ADDR_WIDTH; the header is left-aligned in the FIFO word.
  assign src_sum_s    = src_base_q + ADDR_WIDTH'(pkt_idx_q);
  assign dst_sum_s    = dst_base_q + ADDR_WIDTH'(pkt_idx_q);
  assign hdr_fields_s = {hdr_ctl_q, pkt_idx_q, dst_sum_s, src_sum_s};
  assign hdr_word_s   = AURORA_DATA_WIDTH'(hdr_fields_s) << PAD_W;
  assign last_pkt_s   = (pkt_idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_idx_q  <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      hdr_ctl_q  <= 9'd0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      pkt_idx_q  <= pkt_idx_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      hdr_ctl_q  <= hdr_ctl_d;
      payload_q  <= payload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = bus.start_encap_pkt ? RD_MEM : IDLE;
      RD_MEM:   state_d = WAIT_MEM;
      WAIT_MEM: state_d = WR_HDR;
      WR_HDR:   state_d = bus.fifo_full ? WR_HDR : WR_DATA;
      WR_DATA: begin
        if (bus.fifo_full) begin
          state_d = WR_DATA;
        end else begin
          state_d = last_pkt_s ? DONE : RD_MEM;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Transfer context is captured only on an accepted start, so input changes mid-transfer are inert.
  always_comb begin
    pkt_idx_d  = pkt_idx_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    hdr_ctl_d  = hdr_ctl_q;
    payload_d  = payload_q;
    case (state_q)
      IDLE: begin
        if (bus.start_encap_pkt) begin
          src_base_d = bus.router_src_addr;
          dst_base_d = bus.router_dst_addr_send;
          hdr_ctl_d  = bus.header_pkt_send;
          pkt_idx_d  = '0;
        end else begin
          pkt_idx_d  = pkt_idx_q;
        end
      end
      WAIT_MEM: payload_d = bus.mem_rd_data;
      WR_DATA: begin
        if (!bus.fifo_full && !last_pkt_s) begin
          pkt_idx_d = pkt_idx_q + PKT_IDX_W'(1);
        end else begin
          pkt_idx_d = pkt_idx_q;
        end
      end
      default: pkt_idx_d = pkt_idx_q;
    endcase
  end

  // The write strobe is gated by the live full flag so a full FIFO is never written.
  always_comb begin
    mem_rd_en_s    = 1'b0;
    mem_rd_addr_s  = '0;
    fifo_wr_en_s   = 1'b0;
    fifo_wr_data_s = '0;
    encap_done_s   = 1'b0;
    encap_busy_s   = (state_q != IDLE);
    case (state_q)
      RD_MEM: begin
        mem_rd_en_s   = 1'b1;
        mem_rd_addr_s = src_sum_s;
      end
      WR_HDR: begin
        fifo_wr_data_s = hdr_word_s;
        fifo_wr_en_s   = !bus.fifo_full;
      end
      WR_DATA: begin
        fifo_wr_data_s = payload_q;
        fifo_wr_en_s   = !bus.fifo_full;
      end
      DONE:    encap_done_s = 1'b1;
      default: encap_done_s = 1'b0;
    endcase
  end

  assign bus.mem_rd_en    = mem_rd_en_s;
  assign bus.mem_rd_addr  = mem_rd_addr_s;
  assign bus.fifo_wr_en   = fifo_wr_en_s;
  assign bus.fifo_wr_data = fifo_wr_data_s;
  assign bus.encap_done   = encap_done_s;
  assign bus.encap_busy   = encap_busy_s;

endmodule

// File: tb/tb_pkt_encapsulator.sv
// Scoreboard bench for pkt_encapsulator: stimulus pushes expected reads, FIFO words and done
// cycles derived from the header/address rules; a negedge monitor pops and compares.
module tb_pkt_encapsulator;
  localparam int N  = 19;
  localparam int AW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_encapsulator_if #(.DW(DW), .AW(AW)) bus ();

  pkt_encapsulator #(
    .AURORA_DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUMBER_PACKET(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0] mem [0:1023];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int bp_mode = 0;
  int bp_base = 0;
  int last_wr_cyc = 0;

  logic [63:0] exp_wr[$];
  logic [9:0]  exp_rd[$];
  int          exp_done[$];
  logic [63:0] wr_log[$];
  logic [63:0] basic_log[$];
  logic [9:0]  rd_log[$];

  // Registered source memory: data valid the cycle after the read strobe.
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] hdr_word(input int src, input int dst, input int hdr, input int k);
    return (64'(hdr % 512) << 55) | (64'(k) << 50) |
           (64'((dst + k) % 1024) << 40) | (64'((src + k) % 1024) << 30);
  endfunction

  task automatic push_model(input int src, input int dst, input int hdr, input int s, input int stalls);
    for (int k = 0; k < N; k++) begin
      exp_rd.push_back(10'((src + k) % 1024));
      exp_wr.push_back(hdr_word(src, dst, hdr, k));
      exp_wr.push_back(mem[(src + k) % 1024]);
    end
    exp_done.push_back(stalls < 0 ? -1 : s + 4 * N + stalls);
  endtask

  task automatic do_start(input int src, input int dst, input int hdr, input int stalls, output int s);
    bus.router_src_addr      = 10'(src);
    bus.router_dst_addr_send = 10'(dst);
    bus.header_pkt_send      = 9'(hdr);
    bus.start_encap_pkt      = 1'b1;
    @(posedge clk); #1;
    bus.start_encap_pkt = 1'b0;
    s = cyc;
    bp_base = s;
    push_model(src, dst, hdr, s, stalls);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_done.size() > 0 || exp_wr.size() > 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      fail({name, "_timeout"});
      exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
  endtask

  // Backpressure driver: off, fixed packet-2 stall pattern, or random.
  initial begin
    bus.fifo_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       bus.fifo_full = ((cyc - bp_base) inside {10, 11, 12, 14, 15});
        2:       bus.fifo_full = ($urandom_range(0, 3) == 0);
        default: bus.fifo_full = 1'b0;
      endcase
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [9:0]  ea;
    int          d;
    if (rst) begin
      chk("rst_wr_data", bus.fifo_wr_data, 64'd0);
      chk("rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
      chk("rst_strobes", {60'd0, bus.mem_rd_en, bus.fifo_wr_en, bus.encap_done, bus.encap_busy}, 64'd0);
    end else begin
      if (!bus.encap_busy) begin
        chk("idle_wr_data", bus.fifo_wr_data, 64'd0);
        chk("idle_strobes", {61'd0, bus.mem_rd_en, bus.fifo_wr_en, bus.encap_done}, 64'd0);
      end
      if (bus.fifo_wr_en) begin
        chk("wr_while_full", 64'(bus.fifo_full), 64'd0);
        if (exp_wr.size() == 0) begin
          fail("unexpected_write");
        end else begin
          e = exp_wr.pop_front();
          chk("fifo_data", bus.fifo_wr_data, e);
        end
        wr_log.push_back(bus.fifo_wr_data);
        last_wr_cyc = cyc;
      end else if (bus.fifo_full && bus.fifo_wr_data != 64'd0 && exp_wr.size() > 0) begin
        chk("hold_stable", bus.fifo_wr_data, exp_wr[0]);
      end
      if (bus.mem_rd_en) begin
        if (exp_rd.size() == 0) begin
          fail("unexpected_read");
        end else begin
          ea = exp_rd.pop_front();
          chk("rd_addr", 64'(bus.mem_rd_addr), 64'(ea));
        end
        rd_log.push_back(bus.mem_rd_addr);
      end
      if (bus.encap_done) begin
        if (exp_done.size() == 0) begin
          fail("unexpected_done");
        end else begin
          d = exp_done.pop_front();
          if (d >= 0) chk("done_cycle", 64'(cyc), 64'(d));
          else        chk("done_after_last", 64'(cyc), 64'(last_wr_cyc + 1));
          chk("done_drained", 64'(exp_wr.size()), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int diffs;
    logic [63:0] w;
    bus.start_encap_pkt      = 1'b0;
    bus.router_src_addr      = 10'd0;
    bus.router_dst_addr_send = 10'd0;
    bus.header_pkt_send      = 9'd0;
    for (int a = 0; a < 1024; a++) mem[a] = 64'hA000_0000_0000_0000 + 64'(a);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic transfer
    clear_logs();
    do_start(32'h010, 32'h200, 32'h1A5, 0, s);
    wait_drain("basic");
    chk("basic_count", 64'(wr_log.size()), 64'd38);
    if (wr_log.size() >= 2) begin
      chk("basic_hdr0", wr_log[0], 64'hD282_0004_0000_0000);
      chk("basic_pay0", wr_log[1], 64'hA000_0000_0000_0010);
    end else fail("basic_log_short");
    basic_log = wr_log;

    // Backpressure: 3 stalls on packet 2 header, 2 on its payload
    clear_logs();
    bp_mode = 1;
    do_start(32'h010, 32'h200, 32'h1A5, 5, s);
    wait_drain("backpressure");
    bp_mode = 0;
    chk("bp_count", 64'(wr_log.size()), 64'(basic_log.size()));
    diffs = 0;
    for (int i = 0; i < wr_log.size() && i < basic_log.size(); i++)
      if (wr_log[i] !== basic_log[i]) diffs++;
    chk("bp_same_contents", 64'(diffs), 64'd0);

    // Address wrap
    clear_logs();
    do_start(32'h3F8, 32'h3FF, 32'h0C3, 0, s);
    wait_drain("wrap");
    if (rd_log.size() == 19 && wr_log.size() == 38) begin
      chk("wrap_rd0", 64'(rd_log[0]), 64'h3F8);
      chk("wrap_rd8", 64'(rd_log[8]), 64'h000);
      chk("wrap_rd18", 64'(rd_log[18]), 64'h00A);
      w = wr_log[2];
      chk("wrap_pkt1_dst", 64'(w[49:40]), 64'h000);
    end else fail("wrap_log_size");

    // Ignored starts mid-transfer and in DONE, then back-to-back start in IDLE
    clear_logs();
    do_start(32'h020, 32'h100, 32'h055, 0, s);
    wait_until(s + 9);
    bus.router_src_addr      = 10'h300;
    bus.router_dst_addr_send = 10'h3C0;
    bus.header_pkt_send      = 9'h0AA;
    bus.start_encap_pkt      = 1'b1;
    @(posedge clk); #1;
    bus.start_encap_pkt = 1'b0;
    wait_until(s + 76);
    bus.router_src_addr      = 10'h0A0;
    bus.router_dst_addr_send = 10'h2C0;
    bus.header_pkt_send      = 9'h111;
    bus.start_encap_pkt      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start_encap_pkt = 1'b0;
    push_model(32'h0A0, 32'h2C0, 32'h111, s + 78, 0);
    wait_drain("ignored_start");
    chk("b2b_count", 64'(wr_log.size()), 64'd76);
    if (rd_log.size() == 38) chk("b2b_second_base", 64'(rd_log[19]), 64'h0A0);
    else fail("b2b_rd_log_size");

    // Mid-transfer reset
    do_start(32'h040, 32'h080, 32'h1FF, 0, s);
    wait_until(s + 29);
    rst = 1'b1;
    exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    clear_logs();
    do_start(32'h040, 32'h080, 32'h1FF, 0, s);
    wait_drain("after_reset");
    chk("rst_recover_count", 64'(wr_log.size()), 64'd38);
    if (wr_log.size() > 0) begin
      w = wr_log[0];
      chk("rst_recover_idx0", 64'(w[54:50]), 64'd0);
    end else fail("rst_recover_empty");

    // Randomized transfers with random memory and random backpressure
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 1024; a++) mem[a] = {$urandom, $urandom};
      bp_mode = 2;
      do_start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 511)), -1, s);
      wait_drain("random");
      bp_mode = 0;
    end

    chk("final_queues_empty", 64'(exp_wr.size() + exp_rd.size() + exp_done.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
